// File: rtl/line_mem_pkg.sv
// Shared definitions for the dcache-to-memory line interface.
// The line width lives here so the cache controller and responder agree on it.
package line_mem_pkg;

   localparam int LINE_BITS   = 256;
   localparam int OFFSET_BITS = 5;

   typedef enum logic {
      IDLE,
      WAIT
   } state_e;

endpackage : line_mem_pkg

// File: rtl/line_mem_array.sv
// Single-port line storage: synchronous write, registered read, no reset.
// Read data reflects the array contents at the previous rising edge.
module line_mem_array
   import line_mem_pkg::*;
#(
   parameter int DEPTH = 512
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] idx_i,
   input  logic [LINE_BITS-1:0]     wdata_i,
   output logic [LINE_BITS-1:0]     rdata_o
);

   logic [LINE_BITS-1:0] mem [DEPTH];
   logic [LINE_BITS-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[idx_i] <= wdata_i;
      end
      rdata_q <= mem[idx_i];
   end

   assign rdata_o = rdata_q;

endmodule : line_mem_array

// File: rtl/line_memory_responder.sv
// Off-chip line memory model: accepts one line read/write at a time, holds it
// for a fixed latency, then completes it with a single-cycle acknowledge.
module line_memory_responder
   import line_mem_pkg::*;
#(
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   input  logic                 write_i,
   input  logic [31:0]          addr_i,
   input  logic [LINE_BITS-1:0] data_i,
   output logic                 ack_o,
   output logic [LINE_BITS-1:0] data_o,
   output logic                 busy_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 wr_q, wr_d;
   logic [LINE_BITS-1:0] line_q, line_d;
   logic [LINE_BITS-1:0] data_q, data_d;
   logic                 ack_q, ack_d;

   logic [IDX_W-1:0]     addr_idx;
   logic [IDX_W-1:0]     mem_idx;
   logic                 mem_we;
   logic [LINE_BITS-1:0] rd_data;
   logic                 unused_addr;

   // Upper bits are dropped so out-of-range addresses wrap onto the array.
   assign addr_idx    = addr_i[OFFSET_BITS +: IDX_W];
   assign unused_addr = ^{addr_i[31:OFFSET_BITS+IDX_W], addr_i[OFFSET_BITS-1:0]};

   line_mem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .idx_i   (mem_idx),
      .wdata_i (line_q),
      .rdata_o (rd_data)
   );

   // In IDLE the array is addressed from the live bus so the registered read
   // already holds the requested line by the time a LATENCY=1 ack fires.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      line_d  = line_q;
      data_d  = data_q;
      ack_d   = 1'b0;
      mem_we  = 1'b0;
      mem_idx = idx_q;

      case (state_q)
         IDLE: begin
            mem_idx = addr_idx;
            if (enable_i) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(LATENCY - 1);
               idx_d   = addr_idx;
               wr_d    = write_i;
               line_d  = data_i;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               ack_d   = 1'b1;
               if (wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  data_d = rd_data;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         line_q  <= '0;
         data_q  <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         line_q  <= line_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
      end
   end

   assign ack_o  = ack_q;
   assign data_o = data_q;
   // The ack cycle still counts as busy even though the FSM is back in IDLE.
   assign busy_o = (state_q == WAIT) || ack_q;

endmodule : line_memory_responder

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_line_memory_responder;
   import line_mem_pkg::*;

   localparam int DEPTH   = 512;
   localparam int LATENCY = 10;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 enable_i;
   logic                 write_i;
   logic [31:0]          addr_i;
   logic [LINE_BITS-1:0] data_i;
   logic                 ack_o;
   logic [LINE_BITS-1:0] data_o;
   logic                 busy_o;

   int checks   = 0;
   int failures = 0;

   localparam logic [LINE_BITS-1:0] PAT_A5 = {32{8'hA5}};
   localparam logic [LINE_BITS-1:0] PAT_4  = {32{8'h3C}};
   localparam logic [LINE_BITS-1:0] PAT_X  = {32{8'hFF}};
   localparam logic [LINE_BITS-1:0] PAT_W  = {8{32'h1234_5670}};
   localparam logic [LINE_BITS-1:0] PAT_1  = {32{8'h11}};
   localparam logic [LINE_BITS-1:0] PAT_5  = {32{8'h5A}};

   line_memory_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (enable_i),
      .write_i  (write_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .ack_o    (ack_o),
      .data_o   (data_o),
      .busy_o   (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [LINE_BITS-1:0] got,
                      input logic [LINE_BITS-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge inside the ack cycle.
   // lat = rising edges from acceptance to the edge that raised ack (-1 on timeout).
   task automatic req(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [LINE_BITS-1:0] data, input bit churn,
                      input bit hold, output int lat);
      enable_i = 1'b1;
      write_i  = wr;
      addr_i   = addr;
      data_i   = data;
      lat      = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk_i);
         if (ack_o) begin
            lat = n - 1;
            break;
         end
         if (churn) begin
            addr_i = $urandom;
            data_i = {8{$urandom}};
         end
      end
      $display("txn %s wr=%0b addr=%h lat=%0d data_o=%h", tag, wr, addr, lat, data_o);
      chk({tag, "_lat"}, LINE_BITS'(lat), LINE_BITS'(LATENCY));
      chk({tag, "_busy_ack"}, LINE_BITS'(busy_o), LINE_BITS'(1));
      if (!hold) enable_i = 1'b0;
   endtask

   int lat;
   int lat2;

   initial begin
      rst_i    = 1'b0;
      enable_i = 1'b0;
      write_i  = 1'b0;
      addr_i   = '0;
      data_i   = '0;
      repeat (2) @(negedge clk_i);
      chk("rst_ack", LINE_BITS'(ack_o), '0);
      chk("rst_data", data_o, '0);
      chk("rst_busy", LINE_BITS'(busy_o), '0);
      rst_i = 1'b1;
      @(negedge clk_i);

      // Preload lines 3 and 4 through the interface
      req("wr_l3", 1'b1, 32'h60, PAT_A5, 1'b0, 1'b0, lat);
      @(negedge clk_i);
      chk("wr_l3_ack_drop", LINE_BITS'(ack_o), '0);
      req("wr_l4", 1'b1, 32'h80, PAT_4, 1'b0, 1'b0, lat);
      @(negedge clk_i);

      // Read latency and data hold after ack
      req("rd_l3", 1'b0, 32'h60, '0, 1'b0, 1'b0, lat);
      chk("rd_l3_data_ack", data_o, PAT_A5);
      @(negedge clk_i);
      chk("rd_l3_ack_one", LINE_BITS'(ack_o), '0);
      chk("rd_l3_busy_idle", LINE_BITS'(busy_o), '0);
      chk("rd_l3_data_hold", data_o, PAT_A5);

      // Reset in the middle of a write to line 4
      enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h80; data_i = PAT_X;
      repeat (4) @(negedge clk_i);
      chk("abort_busy_pre", LINE_BITS'(busy_o), LINE_BITS'(1));
      rst_i    = 1'b0;
      enable_i = 1'b0;
      #1;
      chk("abort_data_async", data_o, '0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         chk("abort_ack", LINE_BITS'(ack_o), '0);
         chk("abort_data", data_o, '0);
         chk("abort_busy", LINE_BITS'(busy_o), '0);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("abort_idle_busy", LINE_BITS'(busy_o), '0);
      req("rd_l4_abort", 1'b0, 32'h80, '0, 1'b0, 1'b0, lat);
      chk("abort_mem4_kept", data_o, PAT_4);
      @(negedge clk_i);

      // Write then read the same line; write ack leaves data_o alone
      req("wr_w", 1'b1, 32'h80, PAT_W, 1'b0, 1'b0, lat);
      chk("wr_w_data_unchanged", data_o, PAT_4);
      @(negedge clk_i);
      req("rd_w", 1'b0, 32'h80, '0, 1'b0, 1'b0, lat);
      chk("rd_w_data", data_o, PAT_W);
      @(negedge clk_i);

      // Back-to-back: enable held across the first ack
      req("b2b_wr_l1", 1'b1, 32'h20, PAT_1, 1'b0, 1'b1, lat);
      req("b2b_rd_l4", 1'b0, 32'h80, '0, 1'b0, 1'b0, lat2);
      chk("b2b_gap", LINE_BITS'(lat2 + 1), LINE_BITS'(LATENCY + 1));
      chk("b2b_data", data_o, PAT_W);
      @(negedge clk_i);

      // Bus churn during WAIT must not disturb the latched request
      req("churn_wr_l5", 1'b1, 32'hA0, PAT_5, 1'b1, 1'b0, lat);
      @(negedge clk_i);
      req("rd_l5", 1'b0, 32'hA0, '0, 1'b0, 1'b0, lat);
      chk("churn_wr_data", data_o, PAT_5);
      @(negedge clk_i);
      req("churn_rd_l1", 1'b0, 32'h20, '0, 1'b1, 1'b0, lat);
      chk("churn_rd_data", data_o, PAT_1);
      @(negedge clk_i);

      // Address wrap: line DEPTH+1 aliases line 1, low offset bits ignored
      req("wrap_rd", 1'b0, DEPTH * 32 + 32'h3F, '0, 1'b0, 1'b0, lat);
      chk("wrap_data", data_o, PAT_1);
      @(negedge clk_i);
      chk("final_ack", LINE_BITS'(ack_o), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_line_memory_responder

// File: doc/line_memory_responder.md
# line_memory_responder

Responder end of the dcache-to-memory line interface: a parameterised off-chip memory model that accepts 256-bit line read/write requests from the data cache controller, holds each request for a fixed latency, and completes it with a one-cycle acknowledge. It sits outside the CPU top at the testbench/system level, driving the cache's memory-side data and acknowledge inputs and consuming its address, data, enable and write outputs.

## Interface
- DEPTH, 512, number of 256-bit lines; power of two
- LATENCY, 10, clock edges from request acceptance to ack; must be at least 1
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- enable_i  in  1  request valid; level, held by the requester until ack
- write_i  in  1  1 = line write, 0 = line read; sampled with enable_i
- addr_i  in  32  byte address; line index = addr_i[5+log2(DEPTH)-1:5]
- data_i  in  256  write line data
- ack_o  out  1  one-cycle completion pulse
- data_o  out  256  read line data, valid while ack_o is high for a read
- busy_o  out  1  high while a request is in flight

## Operation
- States: IDLE and WAIT.
- IDLE: if enable_i is 1 at a rising edge, the responder accepts the request. It latches the index, write_i and data_i, loads cnt = LATENCY-1, and moves to WAIT. Otherwise it stays in IDLE.
- WAIT: cnt decrements each edge. On the edge where cnt = 0:
  - ack_o is set to 1 for exactly one cycle and the state returns to IDLE.
  - Read: data_o is loaded with mem[idx].
  - Write: mem[idx] is loaded with the latched data, and data_o is unchanged.
- After an ack, the responder is in IDLE. If enable_i is still 1 at the next edge, that edge accepts a new request, so back-to-back requests cost LATENCY+1 cycles each.
- Changes on addr_i, data_i or write_i during WAIT are ignored because the request was latched at acceptance.
- Addresses beyond DEPTH lines wrap: upper address bits are dropped. addr_i[4:0] is ignored.
- data_o holds its value between read acks.
- Memory contents are not reset. They are loaded by the bench via hierarchical access or $readmemb.

## Timing
- Reset (rst_i = 0, asynchronous) forces:
  - state to IDLE, cnt to 0
  - ack_o = 0, data_o = 0, busy_o = 0
- A request in flight when reset asserts is aborted, and no memory write occurs.
- Latency: acceptance at edge N gives ack_o high in the cycle after edge N+LATENCY.
- busy_o is high from edge N up to and including the ack cycle.
- With LATENCY = 1, ack_o rises at the first edge after acceptance.
- enable_i falling during WAIT (protocol violation) does not cancel the request. The ack is still issued.
- Read-after-write to the same line in consecutive requests returns the newly written data.

## Structure
- Shared package line_mem_pkg holds:
  - LINE_BITS = 256 and OFFSET_BITS = 5
  - the state enum {IDLE, WAIT}
- The package is shared with the dcache controller so the line width is defined once.
- One sub-module, line_mem_array: a synchronous single-port DEPTH×256 array with write-enable, index in and data in/out. It contains no reset logic.
- FSM, counter and request latch live in the top module.

## Test plan
- Reset: hold rst_i = 0 for 3 cycles mid-WAIT, then release.
  - Required: ack_o = 0, data_o = 0, busy_o = 0 throughout.
  - Required: the aborted write to line 4 leaves mem[4] unchanged.
- Read latency: preload mem[3] = 256'hA5…A5, then hold enable_i = 1, write_i = 0, addr_i = 32'h60.
  - Required: ack_o high for exactly one cycle, 10 edges after acceptance.
  - Required: data_o = A5…A5 during and after the ack.
- Write then read: write 256'h1234…0 to addr 32'h80, deassert enable_i for 1 cycle, then read addr 32'h80.
  - Required: the read ack returns 256'h1234…0.
  - Required: data_o is unchanged at the write ack.
- Back-to-back: keep enable_i = 1 across the ack with a new addr.
  - Required: the second ack arrives exactly 11 edges after the first.
- Input churn and wrap:
  - Toggle addr_i and data_i every cycle during WAIT. Required: the operation uses the values latched at acceptance.
  - Read addr DEPTH*32 + 32'h20. Required: returns mem[1].
